plb_update_stage: RTL and testbench
===================================

PLB_UPDATE_STAGE -- requirements
Module: plb_update_stage

Interface
REQ-001 SHALL have parameter PIPELINE_DATA_WIDTH, default $bits(mptw_transaction_t); width of the slave and master data ports.
REQ-002 SHALL have parameter PLB_DATA_WIDTH, default 64; PLB write-data width.
REQ-003 SHALL have parameter PLB_ADDR_WIDTH, default 64; PLB tag/address width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- stage_slave_valid  in  1  upstream transaction valid.
- stage_slave_ready  out  1  stage can accept.
- stage_slave_data  in  PIPELINE_DATA_WIDTH  mptw_transaction_t.
- stage_master_valid  out  1  output transaction valid.
- stage_master_ready  in  1  downstream accepts.
- stage_master_data  out  PIPELINE_DATA_WIDTH  forwarded transaction.
- stage_ctrl_flush  in  $bits(mptw_flush_ctrl_e)  flush request.
- stage_status_flushed  out  $bits(mptw_flush_status_e)  flush status.
- plb_master_mem_req  out  1  PLB request.
- plb_master_mem_gnt  in  1  request accepted.
- plb_master_mem_valid  in  1  write response.
- plb_master_mem_addr  out  PLB_ADDR_WIDTH  tag, equal to the transaction spa, zero-extended.
- plb_master_mem_wdata  out  PLB_DATA_WIDTH  constant 1 (PLB entry valid).
- plb_master_mem_we  out  1  always 1 while req is high.
- plb_master_mem_be  out  PLB_DATA_WIDTH/8  all ones.
- plb_master_mem_rdata  in  PLB_DATA_WIDTH  ignored.
- plb_master_mem_error  in  1  write error, sampled with valid.
- plb_update_count  out  16  number of successful PLB fills.

Function
REQ-006 SHALL implement the FSM IDLE, REQ, RESP, OUT, with one holding register for the transaction.
REQ-007 In IDLE, stage_slave_ready SHALL be 1; in all other states it SHALL be 0.
REQ-008 On a slave handshake, the stage SHALL capture the data and compute fill = valid && completed && !plb_hit && format_error==NO_ERROR.
REQ-009 On capture with fill=1, the next state SHALL be REQ; with fill=0, OUT (1-cycle bypass latency).
REQ-010 In REQ, req SHALL be 1 with addr/wdata/we/be stable; gnt=1 -> RESP; gnt=0 -> hold.
REQ-011 In RESP, req SHALL be 0; valid=1 -> OUT.
- If error=0 at that valid, plb_update_count SHALL increment, saturating at 16'hFFFF.
- If error=1, the count SHALL be unchanged and the transaction forwarded unmodified.
- The PLB is advisory, so a write error SHALL NOT alter the transaction.
REQ-012 gnt and valid in the same cycle while in REQ SHALL go directly to OUT, with the counter rule of REQ-011 applied.
REQ-013 In OUT, stage_master_valid SHALL be 1 and data SHALL equal the captured transaction with plb_hit set to 1 when the fill succeeded; otherwise the data SHALL be unchanged.
- Master data SHALL stay stable until stage_master_ready.
- Handshake SHALL return to IDLE; no back-to-back accept in the same cycle.
REQ-014 Throughput SHALL be at most one transaction per 2 cycles on bypass and per 3 cycles or more on fill.
REQ-015 Flush (stage_ctrl_flush==MPT_FLUSH):
- IDLE/OUT: drop the held transaction, go to IDLE, status MPT_FLUSHED_COMPLETED the next cycle.
- REQ without gnt that cycle: deassert req next cycle, go to IDLE, status COMPLETED.
- REQ with gnt, or RESP: status MPT_FLUSHED_ONGOING until valid arrives, then IDLE and COMPLETED; the count still updates; no master output.
REQ-016 While flush is held, slave_ready SHALL be 0; status SHALL return to MPT_FLUSHED_NONE the cycle after flush deasserts.
REQ-017 Unknown flush-ctrl encodings SHALL be treated as no flush.

Reset
REQ-018 On rst_i=1 at a clock edge:
- state SHALL be IDLE, holding register cleared, plb_update_count 0, stage_status_flushed MPT_FLUSHED_NONE.
- req, stage_master_valid SHALL be 0; stage_slave_ready SHALL be 1 after release.
REQ-019 Reset mid-REQ/RESP SHALL abandon the outstanding PLB access; a later stray mem_valid in IDLE SHALL be ignored.

Verification
REQ-020 Miss fill: completed=1, plb_hit=0, spa=0x8000_1000, gnt after 2 cycles, valid 1 cycle later, error=0 -> addr=0x8000_1000, wdata=1, we=1, be=0xFF; output plb_hit=1; count=1.
REQ-021 Bypass: plb_hit=1 -> no req; output data bit-identical after 1 cycle; count unchanged.
REQ-022 Backpressure: stage_master_ready=0 for 5 cycles -> master_valid high, data stable, slave_ready=0, then one handshake.
REQ-023 Write error: error=1 on valid -> output plb_hit=0, count unchanged.
REQ-024 Flush in RESP: status ONGOING until valid, then COMPLETED; no master_valid; count incremented.
REQ-025 Saturation: count preloaded to 0xFFFF via 65535 fills (or force), then one more fill -> count stays 0xFFFF.

Source files
------------

// File: rtl/plb_update_stage.sv
// -----------------------------------------------------------------------------
// plb_update_pkg / plb_update_stage
//
// Purpose: one pipeline stage of the page-table walker. It holds a single
// transaction. If the walk has completed, the translation missed the PLB, and
// the format is clean, the stage writes a valid entry into the PLB (tag = spa)
// before it forwards the transaction. All other transactions bypass the PLB.
// A failed PLB write is only advisory: the transaction is forwarded with
// plb_hit left at 0. A flush drops the held transaction. If a PLB write has
// already been granted, the flush waits for that write's response first.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   stage_slave_*           upstream valid/ready/data handshake
//   stage_master_*          downstream valid/ready/data handshake
//   stage_ctrl_flush        flush request (mptw_flush_ctrl_e encoding)
//   stage_status_flushed    flush progress (mptw_flush_status_e encoding)
//   plb_master_mem_*        PLB write port (req/gnt, then valid/error)
//   plb_update_count        saturating count of successful PLB fills
// -----------------------------------------------------------------------------
package plb_update_pkg;

    typedef enum logic [1:0] {
        NO_ERROR     = 2'd0,
        ERR_ALIGN    = 2'd1,
        ERR_RESERVED = 2'd2,
        ERR_PERM     = 2'd3
    } mptw_format_error_e;

    // Encodings 2 and 3 are unassigned; the stage treats them as "no flush".
    typedef enum logic [1:0] {
        MPT_NO_FLUSH = 2'd0,
        MPT_FLUSH    = 2'd1
    } mptw_flush_ctrl_e;

    typedef enum logic [1:0] {
        MPT_FLUSHED_NONE      = 2'd0,
        MPT_FLUSHED_ONGOING   = 2'd1,
        MPT_FLUSHED_COMPLETED = 2'd2
    } mptw_flush_status_e;

    typedef struct packed {
        logic [15:0]        id;
        logic [55:0]        spa;
        mptw_format_error_e format_error;
        logic               plb_hit;
        logic               completed;
        logic               valid;
    } mptw_transaction_t;

endpackage

module plb_update_stage
    import plb_update_pkg::*;
#(
    parameter int PIPELINE_DATA_WIDTH = $bits(mptw_transaction_t),
    parameter int PLB_DATA_WIDTH      = 64,
    parameter int PLB_ADDR_WIDTH      = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,

    input  logic                                  stage_slave_valid,
    output logic                                  stage_slave_ready,
    input  logic [PIPELINE_DATA_WIDTH-1:0]        stage_slave_data,

    output logic                                  stage_master_valid,
    input  logic                                  stage_master_ready,
    output logic [PIPELINE_DATA_WIDTH-1:0]        stage_master_data,

    input  logic [$bits(mptw_flush_ctrl_e)-1:0]   stage_ctrl_flush,
    output logic [$bits(mptw_flush_status_e)-1:0] stage_status_flushed,

    output logic                                  plb_master_mem_req,
    input  logic                                  plb_master_mem_gnt,
    input  logic                                  plb_master_mem_valid,
    output logic [PLB_ADDR_WIDTH-1:0]             plb_master_mem_addr,
    output logic [PLB_DATA_WIDTH-1:0]             plb_master_mem_wdata,
    output logic                                  plb_master_mem_we,
    output logic [PLB_DATA_WIDTH/8-1:0]           plb_master_mem_be,
    input  logic [PLB_DATA_WIDTH-1:0]             plb_master_mem_rdata,
    input  logic                                  plb_master_mem_error,

    output logic [15:0]                           plb_update_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_OUT
    } state_e;

    state_e             state_q, state_d;
    mptw_transaction_t  hold_q, hold_d;
    logic               fill_ok_q, fill_ok_d;   // PLB write for the held txn succeeded
    logic               drain_q, drain_d;       // a flush arrived after the grant; drop on response
    logic [15:0]        count_q, count_d;
    mptw_flush_status_e status_q, status_d;

    mptw_transaction_t  slave_txn;
    mptw_transaction_t  out_txn;
    logic               flush;
    logic               fill_now;
    logic [15:0]        count_inc;

    // The read-data bus of the PLB port carries nothing for writes.
    logic               unused_rdata;
    assign unused_rdata = ^plb_master_mem_rdata;

    assign slave_txn = stage_slave_data[$bits(mptw_transaction_t)-1:0];
    assign flush     = (stage_ctrl_flush == MPT_FLUSH);
    assign fill_now  = slave_txn.valid && slave_txn.completed &&
                       !slave_txn.plb_hit && (slave_txn.format_error == NO_ERROR);
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        fill_ok_d = fill_ok_q;
        drain_d   = drain_q;
        count_d   = count_q;
        status_d  = MPT_FLUSHED_NONE;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    status_d = MPT_FLUSHED_COMPLETED;
                end else if (stage_slave_valid) begin
                    hold_d    = slave_txn;
                    fill_ok_d = 1'b0;
                    drain_d   = 1'b0;
                    state_d   = fill_now ? S_REQ : S_OUT;
                end
            end

            S_REQ: begin
                if (plb_master_mem_gnt) begin
                    if (plb_master_mem_valid) begin
                        // Grant and response in the same cycle skip RESP.
                        fill_ok_d = !plb_master_mem_error;
                        if (!plb_master_mem_error) count_d = count_inc;
                        if (flush) begin
                            state_d  = S_IDLE;
                            status_d = MPT_FLUSHED_COMPLETED;
                        end else begin
                            state_d  = S_OUT;
                        end
                    end else begin
                        state_d = S_RESP;
                        if (flush) begin
                            drain_d  = 1'b1;
                            status_d = MPT_FLUSHED_ONGOING;
                        end
                    end
                end else if (flush) begin
                    // Not granted yet, so the request can simply be withdrawn.
                    state_d  = S_IDLE;
                    status_d = MPT_FLUSHED_COMPLETED;
                end
            end

            S_RESP: begin
                if (flush) drain_d = 1'b1;
                if (plb_master_mem_valid) begin
                    fill_ok_d = !plb_master_mem_error;
                    if (!plb_master_mem_error) count_d = count_inc;
                    if (drain_q || flush) begin
                        state_d  = S_IDLE;
                        status_d = MPT_FLUSHED_COMPLETED;
                    end else begin
                        state_d  = S_OUT;
                    end
                end else if (drain_q || flush) begin
                    status_d = MPT_FLUSHED_ONGOING;
                end
            end

            S_OUT: begin
                if (flush) begin
                    state_d  = S_IDLE;
                    status_d = MPT_FLUSHED_COMPLETED;
                end else if (stage_master_ready) begin
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments, so every register
    // samples the values from before the edge, whatever order the statements
    // are in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            fill_ok_q <= 1'b0;
            drain_q   <= 1'b0;
            count_q   <= 16'd0;
            status_q  <= MPT_FLUSHED_NONE;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            fill_ok_q <= fill_ok_d;
            drain_q   <= drain_d;
            count_q   <= count_d;
            status_q  <= status_d;
        end
    end

    always_comb begin
        out_txn         = hold_q;
        out_txn.plb_hit = hold_q.plb_hit | fill_ok_q;
    end

    assign stage_slave_ready    = (state_q == S_IDLE) && !flush;
    assign stage_master_valid   = (state_q == S_OUT);
    assign stage_master_data    = PIPELINE_DATA_WIDTH'(out_txn);
    assign stage_status_flushed = status_q;

    assign plb_master_mem_req   = (state_q == S_REQ);
    assign plb_master_mem_addr  = PLB_ADDR_WIDTH'(hold_q.spa);
    assign plb_master_mem_wdata = PLB_DATA_WIDTH'(1);
    assign plb_master_mem_we    = plb_master_mem_req;
    assign plb_master_mem_be    = '1;

    assign plb_update_count     = count_q;

endmodule

// File: tb/tb_plb_update_stage.sv
// -----------------------------------------------------------------------------
// tb_plb_update_stage
//
// Self-checking bench for plb_update_stage. A driver issues transactions and
// pushes the expected forwarded transaction and fill count into a scoreboard.
// A monitor pops and compares entries on each downstream handshake. A PLB
// responder follows a per-fill plan (grant delay, response delay, error) and
// checks the write attributes. The reference rules are applied directly to
// the transaction fields.
// -----------------------------------------------------------------------------
module tb_plb_update_stage;
    import plb_update_pkg::*;

    localparam int TW = $bits(mptw_transaction_t);

    logic            clk = 1'b0;
    logic            rst;
    logic            slave_valid;
    logic            slave_ready;
    logic [TW-1:0]   slave_data;
    logic            master_valid;
    logic            master_ready;
    logic [TW-1:0]   master_data;
    logic [1:0]      flush_ctrl;
    logic [1:0]      flush_status;
    logic            plb_req;
    logic            plb_gnt;
    logic            plb_valid;
    logic [63:0]     plb_addr;
    logic [63:0]     plb_wdata;
    logic            plb_we;
    logic [7:0]      plb_be;
    logic [63:0]     plb_rdata;
    logic            plb_error;
    logic [15:0]     update_count;

    plb_update_stage dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .stage_slave_valid    (slave_valid),
        .stage_slave_ready    (slave_ready),
        .stage_slave_data     (slave_data),
        .stage_master_valid   (master_valid),
        .stage_master_ready   (master_ready),
        .stage_master_data    (master_data),
        .stage_ctrl_flush     (flush_ctrl),
        .stage_status_flushed (flush_status),
        .plb_master_mem_req   (plb_req),
        .plb_master_mem_gnt   (plb_gnt),
        .plb_master_mem_valid (plb_valid),
        .plb_master_mem_addr  (plb_addr),
        .plb_master_mem_wdata (plb_wdata),
        .plb_master_mem_we    (plb_we),
        .plb_master_mem_be    (plb_be),
        .plb_master_mem_rdata (plb_rdata),
        .plb_master_mem_error (plb_error),
        .plb_update_count     (update_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [55:0] spa;
        int          gd;    // cycles of req without gnt
        int          vd;    // cycles from gnt to valid (0 = same cycle)
        bit          err;
    } plan_t;

    typedef struct {
        mptw_transaction_t data;
        logic [15:0]       cnt;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [15:0] model_cnt;
    int          n_checks;
    int          n_errors;
    bit          plb_busy;
    int          gnt_count;
    bit          rdy_rand;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mptw_transaction_t mk(input logic [55:0] spa, input logic hit);
        mptw_transaction_t t;
        t              = '0;
        t.valid        = 1'b1;
        t.completed    = 1'b1;
        t.plb_hit      = hit;
        t.format_error = NO_ERROR;
        t.spa          = spa;
        t.id           = 16'($urandom);
        return t;
    endfunction

    // Reference rules: a fill happens for a completed, valid, missing, well-formed
    // walk; a successful fill sets plb_hit and bumps the saturating count.
    task automatic send(input mptw_transaction_t t, input int gd, input int vd,
                        input bit err, input bit expect_out);
        exp_t  e;
        plan_t p;
        bit    fill;
        int    n;
        fill   = t.valid && t.completed && !t.plb_hit && (t.format_error == NO_ERROR);
        e.data = t;
        if (fill) begin
            p.spa = t.spa; p.gd = gd; p.vd = vd; p.err = err;
            plan_q.push_back(p);
            if (!err) begin
                if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
                e.data.plb_hit = 1'b1;
            end
        end
        e.cnt = model_cnt;
        if (expect_out) exp_q.push_back(e);
        slave_valid = 1'b1;
        slave_data  = t;
        n = 0;
        while (!slave_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!slave_ready) check("slave_accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        slave_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0 || plb_busy) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= budget) check("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_gnt(input int g0);
        int n;
        n = 0;
        while (gnt_count == g0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (gnt_count == g0) check("gnt_wait_timeout", 1'b0, 1'b1);
    endtask

    // Monitor: compare each downstream handshake with the scoreboard.
    always @(negedge clk) begin
        if (master_valid && master_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", master_valid, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", master_data, e.data);
                check("out_count", update_count, e.cnt);
            end
        end
    end

    // Random downstream readiness when enabled.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) master_ready = ($urandom_range(0, 3) != 0);
    end

    // PLB responder: serves each request according to the next plan entry.
    initial begin
        plan_t p;
        bit    aborted;
        plb_gnt = 1'b0; plb_valid = 1'b0; plb_error = 1'b0; plb_rdata = '0;
        plb_busy = 1'b0; gnt_count = 0;
        forever begin
            @(posedge clk); #1;
            if (rst || !plb_req) continue;
            if (plan_q.size() == 0) begin
                check("stray_req", plb_req, 1'b0);
                continue;
            end
            p = plan_q.pop_front();
            plb_busy = 1'b1;
            check("plb_addr", plb_addr, {8'h00, p.spa});
            check("plb_wdata", plb_wdata, 64'd1);
            check("plb_we", plb_we, 1'b1);
            check("plb_be", plb_be, 8'hFF);
            aborted = 1'b0;
            for (int i = 0; i < p.gd; i++) begin
                @(posedge clk); #1;
                if (!plb_req) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) begin
                plb_gnt = 1'b1;
                if (p.vd == 0) begin
                    plb_valid = 1'b1; plb_error = p.err;
                end
                @(posedge clk); #1;
                plb_gnt = 1'b0; plb_valid = 1'b0; plb_error = 1'b0;
                gnt_count++;
                if (p.vd > 0) begin
                    for (int i = 1; i < p.vd; i++) begin
                        @(posedge clk); #1;
                    end
                    plb_valid = 1'b1; plb_error = p.err;
                    @(posedge clk); #1;
                    plb_valid = 1'b0; plb_error = 1'b0;
                end
            end
            plb_busy = 1'b0;
        end
    end

    initial begin
        mptw_transaction_t t;
        int                g0;
        int                n;
        n_checks = 0; n_errors = 0; model_cnt = 16'd0;
        rst = 1'b1; slave_valid = 1'b0; slave_data = '0; master_ready = 1'b1;
        flush_ctrl = MPT_NO_FLUSH; rdy_rand = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_req", plb_req, 1'b0);
        check("rst_master_valid", master_valid, 1'b0);
        check("rst_count", update_count, 16'd0);
        check("rst_status", flush_status, MPT_FLUSHED_NONE);
        rst = 1'b0;
        @(posedge clk); #2;
        check("rst_slave_ready", slave_ready, 1'b1);

        // Miss fill: grant after 2 cycles, response 1 cycle later.
        send(mk(56'h8000_1000, 1'b0), 2, 1, 1'b0, 1'b1);
        wait_drain(100);
        check("fill_count", update_count, 16'd1);

        // Bypass: forwarded one cycle after capture, no PLB request.
        send(mk(56'h1234_5678, 1'b1), 0, 0, 1'b0, 1'b1);
        check("bypass_latency", master_valid, 1'b1);
        check("bypass_no_req", plb_req, 1'b0);
        wait_drain(100);
        check("bypass_count", update_count, model_cnt);

        // Backpressure for 5 cycles on a bypass transaction.
        master_ready = 1'b0;
        t = mk(56'h00AB_CDEF, 1'b1);
        send(t, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", master_valid, 1'b1);
            check("bp_data", master_data, t);
            check("bp_slave_ready", slave_ready, 1'b0);
        end
        master_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_single_handshake", master_valid, 1'b0);
        wait_drain(100);

        // Write error: forwarded unmodified, count unchanged.
        send(mk(56'h0000_2000, 1'b0), 1, 2, 1'b1, 1'b1);
        wait_drain(100);
        check("err_count", update_count, model_cnt);

        // Flush while waiting for the response.
        g0 = gnt_count;
        send(mk(56'h0000_3000, 1'b0), 0, 4, 1'b0, 1'b0);
        wait_gnt(g0);
        flush_ctrl = MPT_FLUSH;
        @(posedge clk); #2;
        check("flush_resp_ongoing", flush_status, MPT_FLUSHED_ONGOING);
        check("flush_resp_slave_ready", slave_ready, 1'b0);
        n = 0;
        while (plb_busy && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("flush_resp_completed", flush_status, MPT_FLUSHED_COMPLETED);
        check("flush_resp_no_out", master_valid, 1'b0);
        check("flush_resp_count", update_count, model_cnt);
        flush_ctrl = MPT_NO_FLUSH;
        @(posedge clk); #2;
        check("flush_resp_none", flush_status, MPT_FLUSHED_NONE);
        check("flush_resp_ready", slave_ready, 1'b1);

        // Flush in REQ before any grant; the plan error bit keeps the model
        // count unchanged because the write never happens.
        send(mk(56'h0000_4000, 1'b0), 20, 0, 1'b1, 1'b0);
        @(posedge clk); #2;
        check("flush_req_pending", plb_req, 1'b1);
        flush_ctrl = MPT_FLUSH;
        @(posedge clk); #2;
        check("flush_req_dropped", plb_req, 1'b0);
        check("flush_req_completed", flush_status, MPT_FLUSHED_COMPLETED);
        check("flush_idle_ready", slave_ready, 1'b0);
        @(posedge clk); #2;
        check("flush_idle_completed", flush_status, MPT_FLUSHED_COMPLETED);
        flush_ctrl = MPT_NO_FLUSH;
        @(posedge clk); #2;
        check("flush_req_none", flush_status, MPT_FLUSHED_NONE);
        wait_drain(100);
        check("flush_req_count", update_count, model_cnt);

        // Unknown flush encoding behaves as no flush.
        flush_ctrl = 2'b11;
        send(mk(56'h0000_5000, 1'b1), 0, 0, 1'b0, 1'b1);
        wait_drain(100);
        check("flush_unknown_status", flush_status, MPT_FLUSHED_NONE);
        flush_ctrl = MPT_NO_FLUSH;

        // Reset during RESP; the later response lands in IDLE and is ignored.
        g0 = gnt_count;
        send(mk(56'h0000_6000, 1'b0), 0, 5, 1'b0, 1'b0);
        wait_gnt(g0);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        model_cnt = 16'd0;
        wait_drain(100);
        @(posedge clk); #2;
        check("stray_valid_count", update_count, model_cnt);
        check("stray_valid_no_out", master_valid, 1'b0);
        check("stray_valid_ready", slave_ready, 1'b1);

        // Saturation: preload the count just below the top, then two fills.
        force dut.count_q = 16'hFFFE;
        @(posedge clk); #2;
        release dut.count_q;
        model_cnt = 16'hFFFE;
        @(posedge clk); #2;
        check("sat_preload", update_count, model_cnt);
        send(mk(56'h0000_7000, 1'b0), 0, 0, 1'b0, 1'b1);
        wait_drain(100);
        send(mk(56'h0000_8000, 1'b0), 1, 1, 1'b0, 1'b1);
        wait_drain(100);
        check("sat_count", update_count, 16'hFFFF);

        // Randomized traffic with random backpressure and PLB timing.
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        model_cnt = 16'd0;
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            t              = '0;
            t.valid        = ($urandom_range(0, 7) != 0);
            t.completed    = ($urandom_range(0, 3) != 0);
            t.plb_hit      = ($urandom_range(0, 3) == 0);
            t.format_error = mptw_format_error_e'(($urandom_range(0, 7) == 0) ?
                                                  $urandom_range(1, 3) : 0);
            t.spa          = {24'($urandom), 32'($urandom)};
            t.id           = 16'($urandom);
            send(t, $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), 1'b1);
        end
        wait_drain(1000);
        rdy_rand = 1'b0;
        master_ready = 1'b1;
        check("rand_final_count", update_count, model_cnt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
